irq_controller: RTL and testbench

- Interrupt controller on the device side of the core's interrupt interface.
- Scans device interrupt lines, qualified by the core's mie CSR output, with a round-robin counter.
- Signals one interrupt at a time to the core:
  - a one-cycle interrupt pulse,
  - a stable mcause value.
- Waits for the core's interrupt-return strobe (issued on mret), then acknowledges the serviced device with a one-cycle pulse.

---
 rtl/irq_controller.sv | 96 +++++++++
 tb/tb_irq_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Round-robin device interrupt controller for the core interrupt interface.
// Presents one interrupt at a time and acknowledges the device after mret.
module irq_controller #(
  parameter  int N_IRQ = 16,
  localparam int IDX_W = $clog2(N_IRQ)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [31:0]      mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o
);

  typedef enum logic [1:0] {
    SCAN,
    TRAP,
    WAIT,
    RET
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IRQ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [N_IRQ-1:0] en;
  logic             hit;
  logic             unused_mie;

  assign en         = mie_i[N_IRQ-1:0];
  assign unused_mie = ^mie_i;
  assign hit        = irq_i[cnt_q] & en[cnt_q];

  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] i
  );
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      SCAN: begin
        if (hit) begin
          idx_d   = cnt_q;
          state_d = TRAP;
        end else begin
          cnt_d = wrap_inc(cnt_q);
        end
      end
      TRAP: state_d = WAIT;
      WAIT: begin
        if (int_rst_i) state_d = RET;
      end
      // resume after the serviced line for fairness
      RET: begin
        cnt_d   = wrap_inc(idx_q);
        state_d = SCAN;
      end
    endcase
  end

  always_comb begin
    int_o     = 1'b0;
    mcause_o  = '0;
    irq_ret_o = '0;
    unique case (state_q)
      SCAN: ;
      TRAP: begin
        int_o    = 1'b1;
        mcause_o = {1'b1, 31'(idx_q)};
      end
      WAIT: mcause_o = {1'b1, 31'(idx_q)};
      RET:  irq_ret_o = N_IRQ'(1) << idx_q;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed stimulus pushes
// expected int/ret events, a negedge monitor pops and compares them.
module tb_irq_controller;
  localparam int N = 16;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic [N-1:0]  irq_i = '0;
  logic [31:0]   mie_i = '0;
  logic          int_rst_i = 1'b0;
  logic          int_o;
  logic [31:0]   mcause_o;
  logic [N-1:0]  irq_ret_o;

  irq_controller #(.N_IRQ(N)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .irq_i     (irq_i),
    .mie_i     (mie_i),
    .int_rst_i (int_rst_i),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .irq_ret_o (irq_ret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          c;
    logic [31:0] v;
  } ev_t;

  ev_t q_int[$];
  ev_t q_ret[$];
  ev_t me;
  int  cyc;
  int  checks = 0;
  int  errors = 0;

  function automatic void chk(
    input string       n,
    input logic [31:0] a,
    input logic [31:0] e
  );
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)",
               n, a, e, cyc);
    end
  endfunction

  always @(posedge clk_i or posedge rst_n_i)
    if (rst_n_i) cyc <= 0;
    else         cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      if (int_o) begin
        if (q_int.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_int cycle %0d mcause %h exp none",
                   cyc, mcause_o);
        end else begin
          me = q_int.pop_front();
          chk("int_cycle", 32'(cyc), 32'(me.c));
          chk("mcause", mcause_o, me.v);
        end
      end
      if (irq_ret_o != '0) begin
        if (q_ret.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexp_ret cycle %0d ret %h exp none",
                   cyc, irq_ret_o);
        end else begin
          me = q_ret.pop_front();
          chk("ret_cycle", 32'(cyc), 32'(me.c));
          chk("irq_ret", 32'(irq_ret_o), me.v);
        end
      end
    end
  end

  task automatic at(input int t);
    while (cyc < t) @(negedge clk_i);
  endtask

  task automatic pulse(input int t, input int n);
    at(t);
    int_rst_i = 1'b1;
    at(t + n);
    int_rst_i = 1'b0;
  endtask

  task automatic exp_int(input int c, input logic [31:0] v);
    q_int.push_back('{c: c, v: v});
  endtask

  task automatic exp_ret(input int c, input logic [31:0] v);
    q_ret.push_back('{c: c, v: v});
  endtask

  initial begin
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b0;

    // idle lap: outputs stay quiet, cnt wraps back to 0 at 16
    for (int i = 0; i < 16; i++) begin
      at(i);
      chk("idle_mcause", mcause_o, 32'h0);
      chk("idle_out", 32'({int_o, irq_ret_o}), 32'h0);
    end

    // single line 5, scan starts at 0
    exp_int(22, 32'h8000_0005);
    exp_ret(27, 32'h0000_0020);
    at(16);
    mie_i = 32'h20;
    irq_i = 16'h0020;
    at(25);
    chk("wait_mcause", mcause_o, 32'h8000_0005);
    chk("wait_int", 32'(int_o), 32'h0);
    pulse(26, 1);
    irq_i = '0;
    chk("ret_mcause", mcause_o, 32'h0);

    // all lines pending but masked, then unmask line 8
    exp_int(95, 32'h8000_0008);
    exp_ret(99, 32'h0000_0100);
    at(28);
    irq_i = 16'hFFFF;
    mie_i = 32'h0;
    at(92);
    mie_i = 32'h100;
    pulse(98, 1);
    irq_i = '0;

    // round robin between lines 3 and 9
    exp_int(101, 32'h8000_0009);
    exp_ret(105, 32'h0000_0200);
    exp_int(116, 32'h8000_0003);
    exp_ret(120, 32'h0000_0008);
    exp_int(127, 32'h8000_0009);
    exp_ret(131, 32'h0000_0200);
    exp_int(142, 32'h8000_0003);
    exp_ret(146, 32'h0000_0008);
    at(100);
    irq_i = 16'h0208;
    mie_i = 32'hFFFF_FFFF;
    pulse(104, 1);
    pulse(119, 1);
    pulse(130, 1);
    pulse(145, 1);
    irq_i = '0;

    // int_rst in SCAN and TRAP ignored; device drop in WAIT
    exp_int(149, 32'h8000_0005);
    exp_ret(155, 32'h0000_0020);
    pulse(147, 1);
    irq_i = 16'h0020;
    pulse(149, 1);
    at(151);
    chk("trap_rst_ign", mcause_o, 32'h8000_0005);
    irq_i = '0;
    pulse(154, 3);

    // reset during WAIT on cause 7
    exp_int(158, 32'h8000_0007);
    irq_i = 16'h0080;
    at(161);
    chk("pre_rst_mcause", mcause_o, 32'h8000_0007);
    rst_n_i = 1'b1;
    #1;
    chk("async_mcause", mcause_o, 32'h0);
    chk("async_ret", 32'(irq_ret_o), 32'h0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b0;

    // scan restarts at 0
    exp_int(8, 32'h8000_0007);
    exp_ret(12, 32'h0000_0080);
    pulse(11, 1);
    irq_i = '0;
    at(24);

    chk("left_int", 32'(q_int.size()), 32'h0);
    chk("left_ret", 32'(q_ret.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
